// File: rtl/sim_run_seq_ctrl.sv
// Run sequencer for the distributed-sim DUT: reset hold, gated run,
// epoch sync handshake with the remote peer, and run/event accounting.
module sim_run_seq_ctrl #(
  parameter int RST_CYCLES   = 10,
  parameter int EPOCH_CYCLES = 16,
  parameter int RUN_CYCLES   = 60,
  parameter int SYNC_TIMEOUT = 100,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             peer_ack,
  input  logic             event_in,
  output logic             dut_reset_n,
  output logic             run_en,
  output logic             sync_req,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] epoch_cnt,
  output logic [CNT_W-1:0] event_cnt,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    RUN,
    SYNC,
    DONE,
    ERROR
  } state_t;

  localparam logic [31:0] HOLD_LAST = 32'(RST_CYCLES);
  localparam logic [31:0] EP_LAST   = 32'(EPOCH_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(SYNC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [31:0]      tmr_q, tmr_d;
  logic [31:0]      ep_q, ep_d;
  logic [CNT_W-1:0] cyc_d, epo_d, evt_d;
  logic             dut_rst_d, run_d, sync_d;
  logic             done_d, err_d;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ep_d    = ep_q;
    cyc_d   = cycle_cnt;
    epo_d   = epoch_cnt;
    evt_d   = event_cnt;
    if (run_en && event_in)
      evt_d = sat_inc(event_cnt);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RST_HOLD;
          tmr_d   = '0;
          ep_d    = '0;
        end
      end
      RST_HOLD: begin
        if (tmr_q == HOLD_LAST)
          state_d = RUN;
        else
          tmr_d = tmr_q + 32'd1;
      end
      RUN: begin
        cyc_d = sat_inc(cycle_cnt);
        ep_d  = (ep_q == EP_LAST) ? '0 : ep_q + 32'd1;
        // the final run cycle wins over an epoch boundary
        if (cycle_cnt == RUN_LAST) begin
          state_d = DONE;
        end else if (ep_q == EP_LAST) begin
          state_d = SYNC;
          tmr_d   = '0;
        end
      end
      SYNC: begin
        if (peer_ack) begin
          state_d = RUN;
          epo_d   = sat_inc(epoch_cnt);
        end else if (tmr_q == TO_LAST) begin
          state_d = ERROR;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      DONE, ERROR: ;
      default: state_d = IDLE;
    endcase
    dut_rst_d = state_d inside {RUN, SYNC, DONE, ERROR};
    run_d     = state_d == RUN;
    sync_d    = state_d == SYNC;
    done_d    = state_d inside {DONE, ERROR};
    err_d     = state_d == ERROR;
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      ep_q        <= '0;
      cycle_cnt   <= '0;
      epoch_cnt   <= '0;
      event_cnt   <= '0;
      dut_reset_n <= 1'b0;
      run_en      <= 1'b0;
      sync_req    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      ep_q        <= ep_d;
      cycle_cnt   <= cyc_d;
      epoch_cnt   <= epo_d;
      event_cnt   <= evt_d;
      dut_reset_n <= dut_rst_d;
      run_en      <= run_d;
      sync_req    <= sync_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule
